// File: rtl/or1200_fwd_ctrl_pkg.sv
// Shared definitions for the OR1200 operand-forwarding controller:
// select encodings, FSM states and default widths.
package or1200_fwd_ctrl_pkg;

    localparam int OR1200_AW        = 5;
    localparam int OR1200_SEL_WIDTH = 2;

    typedef logic [OR1200_SEL_WIDTH-1:0] sel_t;

    localparam sel_t OR1200_SEL_RF      = 2'd0;
    localparam sel_t OR1200_SEL_IMM     = 2'd1;
    localparam sel_t OR1200_SEL_EX_FORW = 2'd2;
    localparam sel_t OR1200_SEL_WB_FORW = 2'd3;

    typedef enum logic {
        RUN     = 1'b0,
        LU_WAIT = 1'b1
    } fwd_state_t;

    // A bubble moves every producer one stage further down the pipe.
    function automatic sel_t sel_age(input sel_t sel);
        case (sel)
            OR1200_SEL_EX_FORW: sel_age = OR1200_SEL_WB_FORW;
            OR1200_SEL_WB_FORW: sel_age = OR1200_SEL_RF;
            default:            sel_age = sel;
        endcase
    endfunction

endpackage

// File: rtl/or1200_fwd_sel.sv
// Hit detection and select priority for one source operand.
module or1200_fwd_sel
    import or1200_fwd_ctrl_pkg::*;
#(
    parameter int AW        = OR1200_AW,
    parameter int SEL_WIDTH = OR1200_SEL_WIDTH
) (
    input  logic                 rd_en,
    input  logic                 imm,
    input  logic [AW-1:0]        src_addr,
    input  logic                 id_wb_en,
    input  logic [AW-1:0]        id_wb_addr,
    input  logic                 ex_wb_en,
    input  logic [AW-1:0]        ex_wb_addr,
    output logic [SEL_WIDTH-1:0] sel
);

    logic src_nz;
    logic id_hit;
    logic ex_hit;

    // r0 is hardwired to zero, so it never forwards.
    assign src_nz = |src_addr;
    assign id_hit = rd_en && src_nz && id_wb_en && (id_wb_addr == src_addr);
    assign ex_hit = rd_en && src_nz && ex_wb_en && (ex_wb_addr == src_addr);

    always_comb begin
        sel = OR1200_SEL_RF;
        if (imm)
            sel = OR1200_SEL_IMM;
        else if (id_hit)
            sel = OR1200_SEL_EX_FORW;
        else if (ex_hit)
            sel = OR1200_SEL_WB_FORW;
    end

endmodule

// File: rtl/or1200_fwd_ctrl.sv
// Operand-forwarding controller: tracks ID/EX destinations, registers the
// operand selects for the instruction in ID and requests load-use stalls.
//
// state   | meaning
// RUN     | normal issue, no outstanding load-use hazard
// LU_WAIT | consumer waits in ID for the load in EX to reach WB
module or1200_fwd_ctrl
    import or1200_fwd_ctrl_pkg::*;
#(
    parameter int AW        = OR1200_AW,
    parameter int SEL_WIDTH = OR1200_SEL_WIDTH,
    parameter int CW        = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_freeze,
    input  logic                 ex_freeze,
    input  logic                 flushpipe,
    input  logic [AW-1:0]        if_rfa_addr,
    input  logic [AW-1:0]        if_rfb_addr,
    input  logic                 if_rfa_en,
    input  logic                 if_rfb_en,
    input  logic                 if_imm,
    input  logic                 if_wb_en,
    input  logic [AW-1:0]        if_wb_addr,
    input  logic                 if_load,
    output logic [SEL_WIDTH-1:0] sel_a,
    output logic [SEL_WIDTH-1:0] sel_b,
    output logic                 lu_stall,
    output logic [CW-1:0]        lu_stall_cnt
);

    logic                 id_wb_en;
    logic [AW-1:0]        id_wb_addr;
    logic                 id_load;
    logic                 ex_wb_en;
    logic [AW-1:0]        ex_wb_addr;
    logic                 ex_load;
    logic [SEL_WIDTH-1:0] sel_a_new;
    logic [SEL_WIDTH-1:0] sel_b_new;
    logic                 lu_hit;
    fwd_state_t           state;
    fwd_state_t           state_nxt;

    or1200_fwd_sel #(.AW(AW), .SEL_WIDTH(SEL_WIDTH)) u_sel_a (
        .rd_en      (if_rfa_en),
        .imm        (1'b0),
        .src_addr   (if_rfa_addr),
        .id_wb_en   (id_wb_en),
        .id_wb_addr (id_wb_addr),
        .ex_wb_en   (ex_wb_en),
        .ex_wb_addr (ex_wb_addr),
        .sel        (sel_a_new)
    );

    or1200_fwd_sel #(.AW(AW), .SEL_WIDTH(SEL_WIDTH)) u_sel_b (
        .rd_en      (if_rfb_en),
        .imm        (if_imm),
        .src_addr   (if_rfb_addr),
        .id_wb_en   (id_wb_en),
        .id_wb_addr (id_wb_addr),
        .ex_wb_en   (ex_wb_en),
        .ex_wb_addr (ex_wb_addr),
        .sel        (sel_b_new)
    );

    // Load data is not available for EX forwarding, only from WB.
    assign lu_hit = id_load &&
                    ((sel_a_new == OR1200_SEL_EX_FORW) || (sel_b_new == OR1200_SEL_EX_FORW));

    always_comb begin
        state_nxt = state;
        if (flushpipe) begin
            state_nxt = RUN;
        end else begin
            case (state)
                RUN: begin
                    if (!id_freeze && lu_hit)
                        state_nxt = LU_WAIT;
                end
                LU_WAIT: begin
                    if (!ex_freeze)
                        state_nxt = (!id_freeze && lu_hit) ? LU_WAIT : RUN;
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= RUN;
        else
            state <= state_nxt;
    end

    assign lu_stall = (state == LU_WAIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_wb_en   <= 1'b0;
            id_wb_addr <= '0;
            id_load    <= 1'b0;
            ex_wb_en   <= 1'b0;
            ex_wb_addr <= '0;
            ex_load    <= 1'b0;
            sel_a      <= OR1200_SEL_RF;
            sel_b      <= OR1200_SEL_RF;
        end else if (flushpipe) begin
            id_wb_en   <= 1'b0;
            id_load    <= 1'b0;
            ex_wb_en   <= 1'b0;
            ex_load    <= 1'b0;
            sel_a      <= OR1200_SEL_RF;
            sel_b      <= OR1200_SEL_RF;
        end else begin
            if (!id_freeze) begin
                id_wb_en   <= if_wb_en;
                id_wb_addr <= if_wb_addr;
                id_load    <= if_load;
                sel_a      <= sel_a_new;
                sel_b      <= sel_b_new;
            end else if (!ex_freeze) begin
                sel_a      <= sel_age(sel_a);
                sel_b      <= sel_age(sel_b);
            end
            if (!ex_freeze) begin
                if (!id_freeze) begin
                    ex_wb_en   <= id_wb_en;
                    ex_wb_addr <= id_wb_addr;
                    ex_load    <= id_load;
                end else begin
                    ex_wb_en   <= 1'b0;
                    ex_load    <= 1'b0;
                end
            end
        end
    end

    // Flush leaves the statistic alone; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            lu_stall_cnt <= '0;
        else if (lu_stall && (lu_stall_cnt != {CW{1'b1}}))
            lu_stall_cnt <= lu_stall_cnt + CW'(1);
    end

endmodule

// File: tb/tb_or1200_fwd_ctrl.sv
// Scoreboard bench for or1200_fwd_ctrl: directed tables plus a random run
// checked against a behavioural model.
module tb_or1200_fwd_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        id_freeze, ex_freeze, flushpipe;
    logic [4:0]  if_rfa_addr, if_rfb_addr, if_wb_addr;
    logic        if_rfa_en, if_rfb_en, if_imm, if_wb_en, if_load;
    logic [1:0]  sel_a, sel_b, s_sel_a, s_sel_b;
    logic        lu_stall, s_lu_stall;
    logic [15:0] lu_stall_cnt;
    logic [3:0]  s_cnt;

    int n_run  = 0;
    int n_fail = 0;
    logic [20:0] sb_q[$];

    typedef struct {
        bit idf, exf, fl, rae, rbe, imm, wbe, ld;
        logic [4:0] ra, rb, wba;
        logic [1:0] sa, sb;
        bit lu;
        logic [15:0] cnt;
    } step_t;

    or1200_fwd_ctrl dut (
        .clk(clk), .rst(rst), .id_freeze(id_freeze), .ex_freeze(ex_freeze),
        .flushpipe(flushpipe), .if_rfa_addr(if_rfa_addr), .if_rfb_addr(if_rfb_addr),
        .if_rfa_en(if_rfa_en), .if_rfb_en(if_rfb_en), .if_imm(if_imm),
        .if_wb_en(if_wb_en), .if_wb_addr(if_wb_addr), .if_load(if_load),
        .sel_a(sel_a), .sel_b(sel_b), .lu_stall(lu_stall), .lu_stall_cnt(lu_stall_cnt)
    );

    // Narrow counter copy, used only to reach saturation quickly.
    or1200_fwd_ctrl #(.CW(4)) dut_s (
        .clk(clk), .rst(rst), .id_freeze(id_freeze), .ex_freeze(ex_freeze),
        .flushpipe(flushpipe), .if_rfa_addr(if_rfa_addr), .if_rfb_addr(if_rfb_addr),
        .if_rfa_en(if_rfa_en), .if_rfb_en(if_rfb_en), .if_imm(if_imm),
        .if_wb_en(if_wb_en), .if_wb_addr(if_wb_addr), .if_load(if_load),
        .sel_a(s_sel_a), .sel_b(s_sel_b), .lu_stall(s_lu_stall), .lu_stall_cnt(s_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [20:0] obs();
        return {sel_a, sel_b, lu_stall, lu_stall_cnt};
    endfunction

    function automatic string fmt(input logic [20:0] v);
        return $sformatf("sel_a=%0d sel_b=%0d lu_stall=%0b cnt=%0d", v[20:19], v[18:17], v[16], v[15:0]);
    endfunction

    function automatic step_t mk(bit idf, bit exf, bit fl, bit rae, logic [4:0] ra,
                                 bit rbe, logic [4:0] rb, bit imm, bit wbe,
                                 logic [4:0] wba, bit ld, logic [1:0] sa,
                                 logic [1:0] sb, bit lu, logic [15:0] cnt);
        step_t s;
        s.idf = idf; s.exf = exf; s.fl = fl; s.rae = rae; s.ra = ra; s.rbe = rbe;
        s.rb = rb; s.imm = imm; s.wbe = wbe; s.wba = wba; s.ld = ld;
        s.sa = sa; s.sb = sb; s.lu = lu; s.cnt = cnt;
        return s;
    endfunction

    function automatic step_t wr(logic [4:0] a, bit ld, logic [1:0] sa, logic [1:0] sb, bit lu, logic [15:0] cnt);
        return mk(0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 1, a, ld, sa, sb, lu, cnt);
    endfunction

    function automatic step_t rd(bit rae, logic [4:0] ra, bit rbe, logic [4:0] rb, bit imm,
                                 logic [1:0] sa, logic [1:0] sb, bit lu, logic [15:0] cnt);
        return mk(0, 0, 0, rae, ra, rbe, rb, imm, 0, 5'd0, 0, sa, sb, lu, cnt);
    endfunction

    function automatic step_t ctl(bit idf, bit exf, bit fl, logic [1:0] sa, logic [1:0] sb, bit lu, logic [15:0] cnt);
        return mk(idf, exf, fl, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, sa, sb, lu, cnt);
    endfunction

    task automatic drive(input bit idf, input bit exf, input bit fl, input bit rae,
                         input logic [4:0] ra, input bit rbe, input logic [4:0] rb,
                         input bit imm, input bit wbe, input logic [4:0] wba, input bit ld);
        id_freeze = idf; ex_freeze = exf; flushpipe = fl;
        if_rfa_en = rae; if_rfa_addr = ra; if_rfb_en = rbe; if_rfb_addr = rb;
        if_imm = imm; if_wb_en = wbe; if_wb_addr = wba; if_load = ld;
    endtask

    task automatic apply(input step_t s);
        drive(s.idf, s.exf, s.fl, s.rae, s.ra, s.rbe, s.rb, s.imm, s.wbe, s.wba, s.ld);
        sb_q.push_back({s.sa, s.sb, s.lu, s.cnt});
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [20:0] e;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 rst = 1'b1;
        #2;
        n_run++;
        if (obs() !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_async: got %s, want all zero", fmt(obs()));
        end
        @(posedge clk); #1 rst = 1'b0;
        apply(ctl(0, 0, 0, 0, 0, 0, 16'd0));
        e = sb_q.pop_front();
        n_run++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL reset_idle: got %s, want %s", fmt(obs()), fmt(e));
        end
    endtask

    task automatic test_forwarding();
        step_t t[$];
        logic [20:0] e;
        t.push_back(wr(5'd3, 0, 0, 0, 0, 0));
        t.push_back(rd(1, 5'd3, 0, 5'd0, 0, 2, 0, 0, 0));
        t.push_back(wr(5'd5, 0, 0, 0, 0, 0));
        t.push_back(wr(5'd6, 0, 0, 0, 0, 0));
        t.push_back(rd(1, 5'd6, 1, 5'd5, 0, 2, 3, 0, 0));
        t.push_back(wr(5'd5, 0, 0, 0, 0, 0));
        t.push_back(wr(5'd6, 0, 0, 0, 0, 0));
        t.push_back(rd(1, 5'd5, 1, 5'd5, 1, 3, 1, 0, 0));
        t.push_back(wr(5'd9, 0, 0, 0, 0, 0));
        t.push_back(wr(5'd9, 0, 0, 0, 0, 0));
        t.push_back(rd(1, 5'd9, 1, 5'd9, 0, 2, 2, 0, 0));
        t.push_back(wr(5'd0, 0, 0, 0, 0, 0));
        t.push_back(wr(5'd0, 0, 0, 0, 0, 0));
        t.push_back(rd(1, 5'd0, 1, 5'd0, 0, 0, 0, 0, 0));
        t.push_back(wr(5'd2, 0, 0, 0, 0, 0));
        t.push_back(rd(0, 5'd2, 0, 5'd2, 0, 0, 0, 0, 0));
        t.push_back(wr(5'd7, 1, 0, 0, 0, 0));
        t.push_back(rd(0, 5'd0, 1, 5'd7, 1, 0, 1, 0, 0));
        foreach (t[i]) begin
            apply(t[i]);
            e = sb_q.pop_front();
            n_run++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL fwd[%0d]: got %s, want %s", i, fmt(obs()), fmt(e));
            end
        end
    endtask

    task automatic test_load_use();
        step_t t[$];
        logic [20:0] e;
        t.push_back(wr(5'd7, 1, 0, 0, 0, 0));
        t.push_back(rd(1, 5'd7, 0, 5'd0, 0, 2, 0, 1, 0));
        t.push_back(ctl(1, 0, 0, 3, 0, 0, 1));
        t.push_back(ctl(0, 0, 0, 0, 0, 0, 1));
        t.push_back(wr(5'd7, 1, 0, 0, 0, 1));
        t.push_back(rd(1, 5'd7, 0, 5'd0, 0, 2, 0, 1, 1));
        for (int k = 0; k < 4; k++)
            t.push_back(ctl(1, 1, 0, 2, 0, 1, 16'(2 + k)));
        t.push_back(ctl(1, 0, 0, 3, 0, 0, 6));
        t.push_back(ctl(0, 0, 0, 0, 0, 0, 6));
        foreach (t[i]) begin
            apply(t[i]);
            e = sb_q.pop_front();
            n_run++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL load_use[%0d]: got %s, want %s", i, fmt(obs()), fmt(e));
            end
        end
    endtask

    task automatic test_flush();
        step_t t[$];
        logic [20:0] e;
        t.push_back(wr(5'd8, 1, 0, 0, 0, 6));
        t.push_back(rd(1, 5'd8, 1, 5'd8, 0, 2, 2, 1, 6));
        t.push_back(ctl(1, 1, 0, 2, 2, 1, 7));
        t.push_back(ctl(1, 1, 1, 0, 0, 0, 8));
        t.push_back(ctl(0, 0, 0, 0, 0, 0, 8));
        t.push_back(wr(5'd8, 0, 0, 0, 0, 8));
        t.push_back(ctl(0, 0, 1, 0, 0, 0, 8));
        t.push_back(rd(1, 5'd8, 1, 5'd8, 0, 0, 0, 0, 8));
        foreach (t[i]) begin
            apply(t[i]);
            e = sb_q.pop_front();
            n_run++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL flush[%0d]: got %s, want %s", i, fmt(obs()), fmt(e));
            end
        end
    endtask

    task automatic test_saturation();
        step_t t[$];
        logic [20:0] e;
        t.push_back(wr(5'd7, 1, 0, 0, 0, 8));
        t.push_back(rd(1, 5'd7, 0, 5'd0, 0, 2, 0, 1, 8));
        for (int k = 0; k < 20; k++)
            t.push_back(ctl(1, 1, 0, 2, 0, 1, 16'(9 + k)));
        t.push_back(ctl(1, 0, 0, 3, 0, 0, 29));
        t.push_back(ctl(0, 0, 0, 0, 0, 0, 29));
        foreach (t[i]) begin
            apply(t[i]);
            e = sb_q.pop_front();
            n_run++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL sat[%0d]: got %s, want %s", i, fmt(obs()), fmt(e));
            end
            if (i == 21 || i == 23) begin
                n_run++;
                if (s_cnt !== 4'd15) begin
                    n_fail++;
                    $display("FAIL sat_cw4[%0d]: got cnt=%0d, want 15", i, s_cnt);
                end
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        step_t t[$];
        logic [20:0] e;
        t.push_back(wr(5'd7, 1, 0, 0, 0, 29));
        t.push_back(rd(1, 5'd7, 0, 5'd0, 0, 2, 0, 1, 29));
        foreach (t[i]) begin
            apply(t[i]);
            e = sb_q.pop_front();
            n_run++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL rst_stall[%0d]: got %s, want %s", i, fmt(obs()), fmt(e));
            end
        end
        #2 rst = 1'b1;
        #1;
        n_run++;
        if (obs() !== 21'd0 || s_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL rst_stall_async: got %s small_cnt=%0d, want all zero", fmt(obs()), s_cnt);
        end
        @(posedge clk); #1 rst = 1'b0;
        apply(ctl(0, 0, 0, 0, 0, 0, 0));
        e = sb_q.pop_front();
        n_run++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL rst_stall_after: got %s, want %s", fmt(obs()), fmt(e));
        end
    endtask

    function automatic logic [1:0] ref_sel(bit rdn, bit imm, logic [4:0] src, bit idw,
                                           logic [4:0] ida, bit exw, logic [4:0] exa);
        if (imm) return 2'd1;
        if (rdn && src != 0 && idw && ida == src) return 2'd2;
        if (rdn && src != 0 && exw && exa == src) return 2'd3;
        return 2'd0;
    endfunction

    function automatic logic [1:0] ref_age(logic [1:0] s);
        return (s == 2'd2) ? 2'd3 : (s == 2'd3) ? 2'd0 : s;
    endfunction

    task automatic test_random(input int n);
        bit m_idw = 0, m_idl = 0, m_exw = 0, m_exl = 0, m_st = 0;
        logic [4:0] m_ida = 0, m_exa = 0;
        logic [1:0] m_sa = 0, m_sb = 0, na, nb;
        logic [15:0] m_cnt = 0;
        bit idf, exf, fl, rae, rbe, imm, wbe, ld, hit;
        logic [4:0] ra, rb, wba;
        logic [20:0] e;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        for (int c = 0; c < n; c++) begin
            idf = ($urandom_range(0, 3) == 0) || m_st;
            exf = ($urandom_range(0, 3) == 0);
            fl  = ($urandom_range(0, 19) == 0);
            rae = 1'($urandom); rbe = 1'($urandom); imm = ($urandom_range(0, 3) == 0);
            wbe = 1'($urandom); ld = 1'($urandom);
            ra = 5'($urandom_range(0, 3)); rb = 5'($urandom_range(0, 3)); wba = 5'($urandom_range(0, 3));
            na = ref_sel(rae, 1'b0, ra, m_idw, m_ida, m_exw, m_exa);
            nb = ref_sel(rbe, imm, rb, m_idw, m_ida, m_exw, m_exa);
            hit = m_idl && (na == 2'd2 || nb == 2'd2);
            if (m_st && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (fl) begin
                m_idw = 0; m_idl = 0; m_exw = 0; m_exl = 0; m_sa = 0; m_sb = 0; m_st = 0;
            end else begin
                if (!m_st) m_st = !idf && hit;
                else if (!exf) m_st = !idf && hit;
                if (!exf) begin
                    if (!idf) begin m_exw = m_idw; m_exa = m_ida; m_exl = m_idl; end
                    else begin m_exw = 0; m_exl = 0; end
                end
                if (!idf) begin
                    m_idw = wbe; m_ida = wba; m_idl = ld; m_sa = na; m_sb = nb;
                end else if (!exf) begin
                    m_sa = ref_age(m_sa); m_sb = ref_age(m_sb);
                end
            end
            sb_q.push_back({m_sa, m_sb, m_st, m_cnt});
            drive(idf, exf, fl, rae, ra, rbe, rb, imm, wbe, wba, ld);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            n_run++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL random[%0d]: got %s, want %s", c, fmt(obs()), fmt(e));
            end
        end
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_flush();
        test_saturation();
        test_reset_mid_stall();
        test_random(400);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
